// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word memory behind the core data port.
// Define MEM_RANGE_CHECK_EN to flag and suppress accesses beyond the array depth.
module data_mem_responder #(
  parameter int ADDR_BITS = 14,
  parameter int LATENCY   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     mem_addr,
  input  logic [3:0][7:0] mem_data_in,
  input  logic            mem_write_en,
  output logic [3:0][7:0] mem_data_out,
  output logic            mem_ready,
  output logic            mem_overrun,
  output logic            mem_error
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                 state_q;
  logic                   stale_q, wr_q;
  logic [3:0]             cnt_q;
  logic [29:0]            word_q, last_word_q;
  logic [31:0]            wdata_q;
  logic [31:0]            mem_q [2**ADDR_BITS];
  logic [29:0]            word_d;
  logic [ADDR_BITS-1:0]   idx;
  logic                   oor, done, req, unused_addr;
  assign word_d      = mem_addr[31:2];
  assign unused_addr = ^mem_addr[1:0];
  assign idx         = word_q[ADDR_BITS-1:0];
  assign done        = state_q == BUSY && cnt_q == 4'd0;
  assign req         = mem_write_en || stale_q || word_d != last_word_q;
`ifdef MEM_RANGE_CHECK_EN
  assign oor = (word_q >> ADDR_BITS) != 30'd0;
`else
  assign oor = 1'b0;
`endif
  // Kept reset-free so it maps onto a plain synchronous RAM.
  always_ff @(posedge clk)
    if (!rst && done && wr_q && !oor) mem_q[idx] <= wdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      stale_q      <= 1'b1;
      cnt_q        <= 4'd0;
      mem_data_out <= '0;
      mem_ready    <= 1'b0;
      mem_overrun  <= 1'b0;
      mem_error    <= 1'b0;
      last_word_q  <= 30'd0;
    end else if (state_q == IDLE) begin
      mem_ready <= !req;
      if (req) begin
        state_q <= BUSY;
        word_q  <= word_d;
        wdata_q <= mem_data_in;
        wr_q    <= mem_write_en;
        cnt_q   <= 4'(LATENCY - 1);
      end
    end else begin
      if (mem_write_en) mem_overrun <= 1'b1;
      cnt_q <= done ? cnt_q : cnt_q - 4'd1;
      if (done) begin
        state_q      <= IDLE;
        stale_q      <= 1'b0;
        last_word_q  <= word_q;
        mem_ready    <= 1'b1;
        mem_error    <= oor;
        mem_data_out <= oor ? 32'h0 : wr_q ? wdata_q : mem_q[idx];
      end
    end
  end
endmodule
